// File: rtl/clk_divider_bank.sv
// clk_divider_bank: bank of NUM_CH independent programmable clock dividers.
// Each channel counts master_clk cycles and inverts its clk_out after div
// cycles, giving a 50% duty square wave of period 2*div. New divisors are
// written into a shadow register and only take effect at the channel's next
// wrap, so the output never produces a short half-period.
//
// Ports:
//   master_clk  single clock, all state updates on its rising edge
//   reset_n     asynchronous active-low reset
//   run         global enable; low holds counters, outputs and divisors
//   sync_clr    realigns every channel to phase zero (priority over run)
//   cfg_we      one-cycle divisor write strobe
//   cfg_ch      target channel for cfg_we
//   cfg_div     new half-period divisor (0 disables the channel)
//   clk_out     per-channel divided clock
//   tick        per-channel one-cycle pulse registered with each toggle
//   cfg_err     one-cycle pulse after a write to a nonexistent channel
//
// Build option: define CLKDIV_TICK_EN to build the tick registers; without
// it the tick port is tied to zero.

module clk_divider_bank #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int DEF_DIV = 50000000
) (
    input  logic              master_clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              cfg_err
);

    localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
    localparam logic [4:0]       NUM_CH_W  = 5'(NUM_CH);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [CNT_W-1:0]  shd_q [NUM_CH];
    logic [CNT_W-1:0]  shd_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] wrap;
    logic              cfg_err_q, cfg_err_d;
    logic              ch_ok;

    assign ch_ok = ({1'b0, cfg_ch} < NUM_CH_W);

    always_comb begin
        cfg_err_d = cfg_we && !ch_ok;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            div_d[i]     = div_q[i];
            shd_d[i]     = shd_q[i];
            pend_d[i]    = pend_q[i];
            clk_out_d[i] = clk_out_q[i];
            wrap[i]      = 1'b0;

            if (sync_clr) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                if (pend_q[i]) begin
                    div_d[i]  = shd_q[i];
                    pend_d[i] = 1'b0;
                end
            end else if (run) begin
                if (div_q[i] == '0) begin
                    // Disabled channel: a pending divisor loads on the next cycle.
                    cnt_d[i] = '0;
                    if (pend_q[i]) begin
                        div_d[i]  = shd_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
                    // div is nonzero here, so div-1 cannot underflow.
                    wrap[i]      = 1'b1;
                    cnt_d[i]     = '0;
                    clk_out_d[i] = ~clk_out_q[i];
                    if (pend_q[i]) begin
                        div_d[i]  = shd_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end

            // A write landing on a wrap cycle is captured after the old shadow
            // has already been consumed above, so it waits for the next wrap.
            if (cfg_we && ch_ok && ({1'b0, cfg_ch} == 5'(i))) begin
                shd_d[i]  = cfg_div;
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DEF_DIV_W;
                shd_q[i] <= DEF_DIV_W;
            end
            pend_q    <= '0;
            clk_out_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
                shd_q[i] <= shd_d[i];
            end
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef CLKDIV_TICK_EN
    logic [NUM_CH-1:0] tick_q;

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= wrap;
        end
    end

    assign tick = tick_q;
`else
    logic unused_wrap;

    assign unused_wrap = ^wrap;
    assign tick        = '0;
`endif

    assign clk_out = clk_out_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: doc/clk_divider_bank.md
CLK_DIVIDER_BANK -- requirements
Module: clk_divider_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter CNT_W, default 32: width of each channel's counter and divisor.
REQ-003 Parameter DEF_DIV, default 50000000: half-period divisor loaded into every channel at reset.
REQ-004 Port master_clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port reset_n  in  1: asynchronous, active-low reset.
REQ-006 Port run  in  1: global enable; when low, all counters and outputs hold.
REQ-007 Port sync_clr  in  1: when high, all channels are realigned to phase zero.
REQ-008 Port cfg_we  in  1: one-cycle write strobe for divisor configuration.
REQ-009 Port cfg_ch  in  4: target channel index for cfg_we.
REQ-010 Port cfg_div  in  CNT_W: new half-period divisor for the target channel.
REQ-011 Port clk_out  out  NUM_CH: per-channel square wave, bit i belongs to channel i.
REQ-012 Port tick  out  NUM_CH: per-channel one-cycle pulse at each clk_out toggle.
REQ-013 Port cfg_err  out  1: one-cycle pulse flagging a rejected write.

Function
REQ-014 Each channel i SHALL hold an active divisor div[i], a shadow divisor shd[i], a pending flag pend[i], a counter cnt[i] and an output bit clk_out[i].
REQ-015 With run=1 and div[i]!=0, cnt[i] SHALL increment by one per cycle; at cnt[i]==div[i]-1 it SHALL wrap to 0, clk_out[i] SHALL invert, and tick[i] SHALL be high for exactly that cycle (registered, same edge as the toggle).
REQ-016 The resulting clk_out[i] period SHALL be 2*div[i] master_clk cycles with a 50% duty cycle; div[i]==1 yields master_clk/2.
REQ-017 div[i]==0 SHALL disable channel i: cnt[i] is held at 0, clk_out[i] is held at its current value, and tick[i] stays 0.
REQ-018 cfg_we with cfg_ch<NUM_CH SHALL write cfg_div to shd[i] and set pend[i]; a later write before the load SHALL overwrite shd[i] (last write wins).
REQ-019 A pending divisor SHALL load into div[i] only on that channel's wrap cycle, or on the next cycle if div[i]==0; the load clears pend[i] and leaves the current half-period unchanged, so the output does not glitch.
REQ-020 cfg_we with cfg_ch>=NUM_CH SHALL change no state and SHALL pulse cfg_err for one cycle starting the cycle after the write.
REQ-021 With run=0, cnt, clk_out and div SHALL hold and tick SHALL be 0; cfg writes are still accepted into the shadow registers; counting resumes from the held count when run returns high.
REQ-022 sync_clr=1 SHALL, on that edge, set every cnt to 0 and every clk_out to 0, load every pending shadow, and force tick to 0; it takes priority over run and over wrap.
REQ-023 A wrap and a cfg_we to the same channel in the same cycle: the wrap SHALL load the old shd value, and the new value is captured into shd with pend set for the next wrap.
REQ-024 The counter compare SHALL be made at CNT_W width with no overflow; div[i]==2^CNT_W-1 SHALL be legal.

Reset
REQ-025 When reset_n is low, asynchronously: cnt=0, clk_out=0, tick=0, cfg_err=0, div=shd=DEF_DIV (truncated to CNT_W), pend=0.
REQ-026 Reset asserted mid-period SHALL abandon the period; after release, the first toggle occurs DEF_DIV cycles after the first rising edge with reset_n high.

Configuration
REQ-027 Macro CLKDIV_TICK_EN defined: the tick logic is built as specified in REQ-015.
REQ-028 Macro CLKDIV_TICK_EN undefined: the tick port SHALL remain present but be tied to all-zeros, with no tick registers; all other behaviour is unchanged.

Verification (NUM_CH=4, CNT_W=8, DEF_DIV=4, CLKDIV_TICK_EN defined)
REQ-029 Release reset, run=1 -> each clk_out toggles every 4 cycles (period 8), tick pulses once per toggle, and all four channels stay in phase.
REQ-030 Write cfg_ch=1, cfg_div=2 mid-period -> ch1 completes its current 4-cycle half-period, then toggles every 2 cycles; ch0, ch2 and ch3 are unaffected.
REQ-031 Write cfg_ch=2, cfg_div=0, then cfg_div=3 -> ch2 freezes at its level with no ticks, then resumes toggling every 3 cycles starting the cycle after the second write loads.
REQ-032 Write cfg_ch=7 -> cfg_err pulses for exactly 1 cycle and no channel changes state.
REQ-033 run=0 for 10 cycles mid-count, then sync_clr pulsed -> outputs frozen during the pause, then all cnt=0 and clk_out=0, and all channels re-toggle together 4 cycles later.
REQ-034 Assert reset_n low between clock edges -> outputs clear immediately without waiting for a clock edge; wrap together with same-channel write follows REQ-023.
